puf_response_deserializer: RTL and testbench
============================================

// Module: puf_response_deserializer
// PURPOSE
//  Downstream consumer of the serial shift-register output: collects a framed serial PUF
//  response bitstream into RESP_WIDTH-bit words. Presents each word on a valid/ready
//  interface to the response-processing logic. Pure single-clock sequential block.
// PARAMETERS
//  RESP_WIDTH  8  bits per response word; legal range >= 2
// PORTS
//  clk        in   1           system clock, all logic on rising edge
//  rst        in   1           synchronous, active-high reset
//  start      in   1           1-cycle pulse: begin capture of a new response word
//  in_bit     in   1           serial data from shift register output
//  in_valid   in   1           in_bit is a valid sample this cycle
//  out_word   out  RESP_WIDTH  assembled response; first received bit in MSB
//  out_valid  out  1           out_word holds a complete response
//  out_ready  in   1           consumer accepts out_word when out_valid & out_ready
//  busy       out  1           1 whenever state != IDLE
//  overrun    out  1           sticky: in_valid seen while in HOLD (bit dropped)
//  out_parity out  1           only when PUF_RESP_PARITY_EN defined (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): state=IDLE, out_word=0, out_valid=0, busy=0, overrun=0,
//    bit count=0, shift reg=0. Reset mid-capture or mid-HOLD discards all data.
//  - FSM states: IDLE, SHIFT, HOLD.
//  - IDLE: start=1 -> SHIFT, count<=0, shift reg<=0. in_valid in IDLE ignored (no overrun).
//  - SHIFT: each in_valid cycle: sreg<={sreg[W-2:0],in_bit}, count++.
//    On in_valid with count==W-1: out_word<={sreg[W-2:0],in_bit}, out_valid<=1, -> HOLD.
//    Latency: out_valid high the cycle after the W-th accepted bit.
//  - start while in SHIFT: restart; count and sreg cleared, in_valid that cycle ignored.
//  - HOLD: out_word/out_valid stable until handshake. out_valid&out_ready -> out_valid<=0
//    next cycle, -> IDLE; if start also high that cycle -> SHIFT directly (count/sreg cleared).
//    start without handshake in HOLD is ignored. in_valid in HOLD sets overrun, bit dropped.
//  - overrun cleared only by rst.
//  - Count width $clog2(RESP_WIDTH); count never exceeds W-1, no wrap.
// CONFIGURATION
//  - PUF_RESP_PARITY_EN defined: out_parity port present; equals ^out_word, registered
//    with out_word; 0 on reset.
//  - Undefined: no out_parity port and no parity logic; all other behaviour identical.
// STRUCTURE
//  - Package puf_pkg: typedef enum logic [1:0] {IDLE,SHIFT,HOLD} deser_state_t;
//    localparam RESP_WIDTH_DEFAULT = 8.
//  - One sub-module: puf_bit_counter (sync clear, enable, terminal-count flag at W-1).
// TESTING  (RESP_WIDTH=8, clk period 10 ns)
//  - Reset: hold rst 2 cycles -> out_word=8'h00, out_valid=0, busy=0, overrun=0.
//  - Basic: start, then bits 1,0,1,1,0,0,1,0 on consecutive in_valid -> out_word=8'hB2,
//    out_valid high cycle after 8th bit; out_ready=1 -> out_valid=0, busy=0 next cycle.
//  - Gapped valid + backpressure: same bits with in_valid idle gaps, out_ready=0 for
//    5 cycles -> out_word=8'hB2 stable throughout; in_valid pulse in HOLD -> overrun=1.
//  - Restart: start, 3 bits, start again, then 8'hFF bits -> out_word=8'hFF only.
//  - Back-to-back: in HOLD assert out_ready & start together -> busy stays 1, next
//    word 8'h5A captured correctly.
//  - Mid-capture reset: rst after 4 bits -> all outputs reset; following 8'h3C
//    captures correctly. With PUF_RESP_PARITY_EN: 8'hB2 -> out_parity=0, 8'h01 -> 1.

Source files
------------

// File: rtl/puf_response_deserializer_pkg.sv
// Shared types and defaults for the PUF response deserializer.
package puf_pkg;

  localparam int unsigned RESP_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } deser_state_t;

endpackage

// File: rtl/puf_response_deserializer_if.sv
// Serial-in / word-out bus of the PUF response deserializer.
// PUF_RESP_PARITY_EN adds the out_parity signal.
interface puf_response_deserializer_if
  import puf_pkg::*;
#(
  parameter int unsigned W = RESP_WIDTH_DEFAULT
);
  logic         start;
  logic         in_bit;
  logic         in_valid;
  logic [W-1:0] out_word;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         overrun;
`ifdef PUF_RESP_PARITY_EN
  logic         out_parity;
`endif

  modport master (
`ifdef PUF_RESP_PARITY_EN
    input  out_parity,
`endif
    output start, in_bit, in_valid, out_ready,
    input  out_word, out_valid, busy, overrun
  );

  modport slave (
`ifdef PUF_RESP_PARITY_EN
    output out_parity,
`endif
    input  start, in_bit, in_valid, out_ready,
    output out_word, out_valid, busy, overrun
  );

endinterface

// File: rtl/puf_response_deserializer_counter.sv
// Received-bit counter: sync clear, enable, saturates with terminal flag at W-1.
module puf_bit_counter #(
  parameter int unsigned W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc_c
);
  localparam int unsigned CW = $clog2(W);

  logic [CW-1:0] count;

  assign tc_c = (count == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !tc_c) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/puf_response_deserializer.sv
// Collects a framed serial PUF response into RESP_WIDTH-bit words (first bit in MSB).
// Optional PUF_RESP_PARITY_EN adds a registered even-parity bit of out_word.
module puf_response_deserializer
  import puf_pkg::*;
#(
  parameter int unsigned RESP_WIDTH = RESP_WIDTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  puf_response_deserializer_if.slave   bus
);
  localparam int unsigned W = RESP_WIDTH;

  deser_state_t state, state_nxt;
  logic [W-2:0] sreg, sreg_nxt;
  logic [W-1:0] word_nxt;
  logic         valid_nxt;
  logic         overrun_nxt;
  logic         cnt_clr, cnt_en, cnt_tc;

  puf_bit_counter #(.W(W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tc_c (cnt_tc)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sreg          <= '0;
      bus.out_word  <= '0;
      bus.out_valid <= 1'b0;
      bus.overrun   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      state         <= state_nxt;
      sreg          <= sreg_nxt;
      bus.out_word  <= word_nxt;
      bus.out_valid <= valid_nxt;
      bus.overrun   <= overrun_nxt;
      bus.busy      <= (state_nxt != IDLE);
    end
  end

`ifdef PUF_RESP_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) bus.out_parity <= 1'b0;
    else     bus.out_parity <= ^word_nxt;
  end
`endif

  // Next-state and datapath control
  always_comb begin
    state_nxt   = state;
    sreg_nxt    = sreg;
    word_nxt    = bus.out_word;
    valid_nxt   = bus.out_valid;
    overrun_nxt = bus.overrun;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = SHIFT;
          sreg_nxt  = '0;
          cnt_clr   = 1'b1;
        end
      end
      SHIFT: begin
        if (bus.start) begin
          sreg_nxt = '0;
          cnt_clr  = 1'b1;
        end else if (bus.in_valid) begin
          sreg_nxt = (W-1)'({sreg, bus.in_bit});
          cnt_en   = 1'b1;
          if (cnt_tc) begin
            word_nxt  = {sreg, bus.in_bit};
            valid_nxt = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.in_valid) overrun_nxt = 1'b1;
        if (bus.out_ready) begin
          valid_nxt = 1'b0;
          if (bus.start) begin
            state_nxt = SHIFT;
            sreg_nxt  = '0;
            cnt_clr   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_puf_response_deserializer.sv
// Randomized + directed self-checking bench for puf_response_deserializer (W=8).
module tb_puf_response_deserializer;
  import puf_pkg::*;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  puf_response_deserializer_if #(.W(W)) bus ();

  puf_response_deserializer #(.RESP_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: bits gathered so far, plus capture/hold flags
  bit          m_cap, m_hold, m_valid, m_overrun;
  logic [W-1:0] m_word;
  bit          q[$];

  function automatic logic [W-1:0] pack_q();
    logic [W-1:0] w = '0;
    foreach (q[i]) w = (w << 1) | W'(q[i]);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_step(input bit r, input bit s, input bit b, input bit v, input bit rd);
    if (r) begin
      m_cap = 0; m_hold = 0; m_valid = 0; m_overrun = 0; m_word = '0; q.delete();
    end else if (m_hold) begin
      if (v) m_overrun = 1;
      if (rd) begin
        m_valid = 0; m_hold = 0;
        if (s) begin m_cap = 1; q.delete(); end
      end
    end else if (m_cap) begin
      if (s) q.delete();
      else if (v) begin
        q.push_back(b);
        if (q.size() == W) begin
          m_word = pack_q(); m_valid = 1; m_hold = 1; m_cap = 0; q.delete();
        end
      end
    end else if (s) begin
      m_cap = 1; q.delete();
    end
  endtask

  // One clock: drive on falling edge, compare just after rising edge
  task automatic cyc(input bit r, input bit s, input bit b, input bit v, input bit rd);
    @(negedge clk);
    rst = r; bus.start = s; bus.in_bit = b; bus.in_valid = v; bus.out_ready = rd;
    model_step(r, s, b, v, rd);
    @(posedge clk);
    #1;
    chk("out_word",  32'(bus.out_word),  32'(m_word));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("busy",      32'(bus.busy),      32'(m_cap || m_hold));
    chk("overrun",   32'(bus.overrun),   32'(m_overrun));
`ifdef PUF_RESP_PARITY_EN
    chk("out_parity", 32'(bus.out_parity), 32'(^m_word));
`endif
  endtask

  task automatic send_word(input logic [W-1:0] v, input bit gaps);
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (gaps) repeat ($urandom_range(0, 2)) cyc(0, 0, 0, 0, 0);
      cyc(0, 0, v[i], 1, 0);
    end
  endtask

  initial begin
    rst = 1; bus.start = 0; bus.in_bit = 0; bus.in_valid = 0; bus.out_ready = 0;
    m_cap = 0; m_hold = 0; m_valid = 0; m_overrun = 0; m_word = '0;

    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_word", 32'(bus.out_word), 32'h00);
    chk("rst_busy", 32'(bus.busy), 32'h0);

    // Basic capture and immediate handshake
    cyc(0, 1, 0, 0, 0);
    send_word(8'hB2, 0);
    chk("basic_word", 32'(bus.out_word), 32'hB2);
    chk("basic_valid", 32'(bus.out_valid), 32'h1);
`ifdef PUF_RESP_PARITY_EN
    chk("par_b2", 32'(bus.out_parity), 32'h0);
`endif
    cyc(0, 0, 0, 0, 1);
    chk("basic_done_busy", 32'(bus.busy), 32'h0);

    // Gapped input, backpressure, overrun in HOLD
    cyc(0, 1, 0, 0, 0);
    send_word(8'hB2, 1);
    repeat (4) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);
    chk("bp_word", 32'(bus.out_word), 32'hB2);
    chk("bp_overrun", 32'(bus.overrun), 32'h1);
    cyc(0, 0, 0, 0, 1);

    // Restart mid-capture
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0); cyc(0, 0, 0, 1, 0); cyc(0, 0, 1, 1, 0);
    cyc(0, 1, 0, 1, 0);
    send_word(8'hFF, 0);
    chk("restart_word", 32'(bus.out_word), 32'hFF);

    // Back-to-back handshake plus start
    cyc(0, 1, 0, 0, 1);
    chk("b2b_busy", 32'(bus.busy), 32'h1);
    send_word(8'h5A, 1);
    chk("b2b_word", 32'(bus.out_word), 32'h5A);

    // Reset mid-capture
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    send_word(8'h0F, 0);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 1, 1, 0); cyc(0, 0, 0, 1, 0); cyc(0, 0, 1, 1, 0); cyc(0, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 0);
    chk("mrst_word", 32'(bus.out_word), 32'h00);
    chk("mrst_overrun", 32'(bus.overrun), 32'h0);
    chk("mrst_busy", 32'(bus.busy), 32'h0);
    cyc(0, 0, 1, 1, 0);
    chk("idle_ignores_valid", 32'(bus.overrun), 32'h0);
    cyc(0, 1, 0, 0, 0);
    send_word(8'h3C, 0);
    chk("mrst_next_word", 32'(bus.out_word), 32'h3C);
    cyc(0, 0, 0, 0, 1);

`ifdef PUF_RESP_PARITY_EN
    cyc(0, 1, 0, 0, 0);
    send_word(8'h01, 0);
    chk("par_01", 32'(bus.out_parity), 32'h1);
    cyc(0, 0, 0, 0, 1);
`endif

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 19) == 0),
          1'($urandom),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
